pwm_motor_rampa: RTL and testbench
==================================

# pwm_motor_rampa

Downstream consumer of the period counter (modulus M, default 24000) in the drone motor path. Compares the counter value `Q` against a duty register to produce one motor PWM output. Accepts new duty targets over a valid/ready handshake. Slews the applied duty toward the target by a bounded step once per PWM period, so the motor soft-starts and never jumps.

## Interface
- `M`, 24000: PWM period in counts; must match the upstream counter modulus.
- `N`, 16: width of `Q` and of all duty values; requires M < 2^N.
- `PASSO`, 100: maximum duty change per period, in counts; 1 ≤ PASSO ≤ M.
- `clock` input 1: single system clock, rising edge.
- `zera_as_n` input 1: asynchronous, active-low reset.
- `Q` input N: counter value, 0..M-1.
- `conta` input 1: counter enable, same signal that drives the counter.
- `fim` input 1: high when Q == M-1.
- `habilita` input 1: motor enable; low forces stop.
- `novo_duty` input N: requested duty target, in counts.
- `carrega` input 1: valid for `novo_duty`.
- `pronto` output 1: ready; a transfer occurs on a clock edge where `carrega` && `pronto`.
- `pwm` output 1: registered PWM output.
- `duty_atual` output N: duty currently applied.
- `em_rampa` output 1: high while in state RAMPA.

## Operation
- Reset (`zera_as_n`=0): state PARADO; `alvo`=0; `duty_atual`=0; `pwm`=0; `pronto`=0; `em_rampa`=0.
- Period boundary: `fronteira` = `fim` && `conta`. This is the cycle in which the counter wraps to 0.
- **PARADO**:
  - While `habilita`=0, the block stays here and any state forces PARADO on the next edge.
  - In PARADO, `alvo`, `duty_atual` and `pwm` are cleared and `pronto`=0.
  - When `habilita`=1 → ESTAVEL.
- **ESTAVEL**:
  - `pronto`=1.
  - On transfer: `alvo` ← min(`novo_duty`, M).
  - If the clamped value ≠ `duty_atual` → RAMPA; otherwise stay.
- **RAMPA**:
  - `pronto`=0; `em_rampa`=1.
  - On each `fronteira`:
    - If `alvo` > `duty_atual`: `duty_atual` += min(PASSO, `alvo` − `duty_atual`).
    - If `alvo` < `duty_atual`: `duty_atual` −= min(PASSO, `duty_atual` − `alvo`).
  - When the updated value equals `alvo` → ESTAVEL on the same edge.
- Arithmetic:
  - Differences are computed in N bits after the comparison, so they never underflow.
  - The sum never exceeds M because the step is bounded by the difference.
- `pwm`:
  - Registered each edge: `pwm` ← `habilita` && (state ≠ PARADO) && (`Q` < `duty_atual`).
  - `duty_atual`=0 gives constant low; `duty_atual`=M gives constant high.
- Counter frozen (`conta`=0): no `fronteira`, so the ramp holds. `pwm` keeps following the static `Q`.
- Simultaneous transfer and `fronteira` in ESTAVEL: no step (alvo == duty_atual); the new `alvo` is stored; → RAMPA.
- Reset mid-ramp: immediate return to the reset values.

## Timing
- `pwm` lags `Q` by exactly 1 clock.
- A `duty_atual` update made on the `fronteira` edge applies starting at the comparison with Q=0.
- Handshake:
  - Transfer completes in 1 cycle.
  - `pronto` falls on the edge after a transfer that changes the target.
  - `pronto` stays high after a transfer equal to `duty_atual`.
- Ramp duration: ceil(|alvo − duty_atual| / PASSO) periods.
- `habilita` falling: `pwm`=0 and `duty_atual`=0 after 1 edge.

## Configuration
- `PWM_RAMPA_EN` defined:
  - Slew-limited ramp as described above.
- Not defined:
  - PASSO is ignored.
  - In RAMPA, the first `fronteira` sets `duty_atual` ← `alvo` and returns to ESTAVEL.
  - All handshake, clamp and reset behaviour is unchanged.

## Test plan
All scenarios use M=20, N=5, PASSO=4, `PWM_RAMPA_EN` defined, and a free-running counter with `conta`=1.
- Reset then `habilita`=1:
  - `pronto`=1 after 1 edge.
  - `pwm`=0 for 3 full periods.
  - `duty_atual`=0.
- Load `novo_duty`=10:
  - `duty_atual` steps 4, 8, 10 on three consecutive `fronteira` edges, then `pronto`=1.
  - In a steady period, `pwm` is high for 10 of 20 cycles, rising 1 cycle after Q=0.
- Load 31:
  - `alvo` clamps to 20; the ramp reaches 20.
  - `pwm` is then constantly high.
  - Loading 0 afterwards ramps down 16, 12, 8, 4, 0.
- Transfer coinciding with `fronteira` in ESTAVEL (duty 8, load 12):
  - No step on that edge.
  - Next `fronteira` gives 12.
- `conta`=0 for 50 cycles mid-ramp: `duty_atual` frozen; it resumes after `conta`=1.
- `habilita`=0 mid-ramp at duty 8:
  - Next edge: `pwm`=0, `duty_atual`=0, `pronto`=0.
  - Assert `zera_as_n`=0 asynchronously between edges: all outputs reach their reset values immediately.

Source files
------------

// File: rtl/pwm_motor_rampa_if.sv
// rtl/pwm_motor_rampa_if.sv - duty-target handshake between a controller and pwm_motor_rampa
//
// Signals:
//   novo_duty [N-1:0] : requested duty target, in counts
//   carrega           : novo_duty is valid
//   pronto            : receiver ready; a transfer happens on an edge with carrega && pronto
interface pwm_motor_rampa_if #(
    parameter int N = 16
);
    logic [N-1:0] novo_duty;
    logic         carrega;
    logic         pronto;

    modport master (
        output novo_duty,
        output carrega,
        input  pronto
    );

    modport slave (
        input  novo_duty,
        input  carrega,
        output pronto
    );
endinterface

// File: rtl/pwm_motor_rampa.sv
// rtl/pwm_motor_rampa.sv - motor PWM comparator with slew-limited duty ramp
//
// Compares the upstream period counter value Q against the applied duty and
// slews the applied duty toward a handshaked target once per PWM period.
//
// Optional feature macro: PWM_RAMPA_EN
//   defined     : duty moves by at most PASSO counts per period
//   not defined : duty jumps to the target on the first period boundary
//
// Ports:
//   clock      : system clock, rising edge
//   zera_as_n  : asynchronous active-low reset
//   Q          : counter value, 0..M-1
//   conta      : counter enable
//   fim        : high when Q == M-1
//   habilita   : motor enable; low forces stop
//   hs         : duty-target handshake (novo_duty / carrega / pronto)
//   pwm        : registered PWM output
//   duty_atual : duty currently applied
//   em_rampa   : high while ramping
module pwm_motor_rampa #(
    parameter int M     = 24000,
    parameter int N     = 16,
    parameter int PASSO = 100
) (
    input  logic                clock,
    input  logic                zera_as_n,
    input  logic [N-1:0]        Q,
    input  logic                conta,
    input  logic                fim,
    input  logic                habilita,
    pwm_motor_rampa_if.slave    hs,
    output logic                pwm,
    output logic [N-1:0]        duty_atual,
    output logic                em_rampa
);

    localparam logic [N-1:0] L_M = N'(M);
`ifdef PWM_RAMPA_EN
    localparam logic [N-1:0] L_STEP = N'(PASSO);
`else
    // A step bound of M never limits, since |alvo - duty| <= M.
    localparam logic [N-1:0] L_STEP = L_M;
`endif

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        ESTAVEL = 2'd1,
        RAMPA   = 2'd2
    } estado_t;

    estado_t      r_estado;
    estado_t      w_estado_prox;
    logic [N-1:0] r_alvo;
    logic [N-1:0] r_duty;
    logic         r_pwm;

    logic         w_fronteira;
    logic         w_xfer;
    logic [N-1:0] w_clamp;
    logic         w_sobe;
    logic [N-1:0] w_dif;
    logic [N-1:0] w_passo;
    logic [N-1:0] w_duty_prox;

    assign w_fronteira = fim && conta;
    assign w_xfer      = hs.carrega && hs.pronto;
    assign w_clamp     = (hs.novo_duty > L_M) ? L_M : hs.novo_duty;

    // Difference is taken after the comparison so it never wraps; the step is
    // bounded by the difference, so the sum never passes alvo (and thus M).
    assign w_sobe      = r_alvo > r_duty;
    assign w_dif       = w_sobe ? (r_alvo - r_duty) : (r_duty - r_alvo);
    assign w_passo     = (w_dif < L_STEP) ? w_dif : L_STEP;
    assign w_duty_prox = w_sobe ? (r_duty + w_passo) : (r_duty - w_passo);

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_estado <= PARADO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        if (!habilita) begin
            w_estado_prox = PARADO;
        end else begin
            case (r_estado)
                PARADO:  w_estado_prox = ESTAVEL;
                ESTAVEL: begin
                    if (w_xfer && (w_clamp != r_duty)) begin
                        w_estado_prox = RAMPA;
                    end
                end
                RAMPA: begin
                    if (w_fronteira && (w_duty_prox == r_alvo)) begin
                        w_estado_prox = ESTAVEL;
                    end
                end
                default: w_estado_prox = PARADO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            r_alvo <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            // Uses the pre-edge duty, so a boundary update first shows at Q=0.
            r_pwm <= habilita && (r_estado != PARADO) && (Q < r_duty);
            if (!habilita || (r_estado == PARADO)) begin
                r_alvo <= '0;
                r_duty <= '0;
            end else if ((r_estado == ESTAVEL) && w_xfer) begin
                r_alvo <= w_clamp;
            end else if ((r_estado == RAMPA) && w_fronteira) begin
                r_duty <= w_duty_prox;
            end
        end
    end

    assign hs.pronto  = (r_estado == ESTAVEL);
    assign em_rampa   = (r_estado == RAMPA);
    assign duty_atual = r_duty;
    assign pwm        = r_pwm;

endmodule

// File: tb/tb_pwm_motor_rampa.sv
// tb/tb_pwm_motor_rampa.sv - randomized self-checking bench for pwm_motor_rampa
module tb_pwm_motor_rampa;

    localparam int M     = 20;
    localparam int N     = 5;
    localparam int PASSO = 4;
`ifdef PWM_RAMPA_EN
    localparam int STEP = PASSO;
`else
    localparam int STEP = M;
`endif

    logic         clock = 1'b0;
    logic         zera_as_n;
    logic [N-1:0] Q;
    logic         conta;
    logic         fim;
    logic         habilita;
    logic         pwm;
    logic [N-1:0] duty_atual;
    logic         em_rampa;

    always #5 clock = ~clock;

    pwm_motor_rampa_if #(.N(N)) hs ();

    assign fim = (Q == N'(M - 1));

    pwm_motor_rampa #(.M(M), .N(N), .PASSO(PASSO)) dut (
        .clock      (clock),
        .zera_as_n  (zera_as_n),
        .Q          (Q),
        .conta      (conta),
        .fim        (fim),
        .habilita   (habilita),
        .hs         (hs.slave),
        .pwm        (pwm),
        .duty_atual (duty_atual),
        .em_rampa   (em_rampa)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: motor on/off, whether a target is pending, target and applied duty.
    bit m_on;
    bit m_busy;
    int m_alvo;
    int m_duty;
    bit m_pwm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_busy = 0; m_alvo = 0; m_duty = 0; m_pwm = 0;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock: advance the reference from pre-edge inputs, let the edge
    // happen, advance the free counter, then compare all outputs.
    task automatic tick();
        int q;
        bit conta_s, fr, xfer, n_pwm;
        q       = Q;
        conta_s = conta;
        fr      = (q == M - 1) && conta_s;
        xfer    = hs.carrega && m_on && !m_busy;
        n_pwm   = habilita && m_on && (q < m_duty);
        if (!habilita) begin
            m_on = 0; m_busy = 0; m_alvo = 0; m_duty = 0;
        end else if (!m_on) begin
            m_on = 1; m_alvo = 0; m_duty = 0;
        end else if (!m_busy) begin
            if (xfer) begin
                m_alvo = imin(int'(hs.novo_duty), M);
                m_busy = (m_alvo != m_duty);
            end
        end else if (fr) begin
            if (m_alvo > m_duty) m_duty = m_duty + imin(STEP, m_alvo - m_duty);
            else                 m_duty = m_duty - imin(STEP, m_duty - m_alvo);
            if (m_duty == m_alvo) m_busy = 0;
        end
        @(posedge clock);
        #1;
        if (conta_s) Q = (q == M - 1) ? '0 : N'(q + 1);
        m_pwm = n_pwm;
        chk("pwm",      pwm,        m_pwm);
        chk("duty",     duty_atual, m_duty);
        chk("pronto",   hs.pronto,  m_on && !m_busy);
        chk("em_rampa", em_rampa,   m_busy);
    endtask

    task automatic load(input int v);
        hs.novo_duty = N'(v);
        hs.carrega   = 1'b1;
        tick();
        hs.carrega   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!hs.pronto && k < budget) begin
            tick();
            k++;
        end
        chk("idle_timeout", hs.pronto, 1);
    endtask

    initial begin
        int hi;
        int saved;
        zera_as_n    = 1'b0;
        Q            = '0;
        conta        = 1'b1;
        habilita     = 1'b0;
        hs.carrega   = 1'b0;
        hs.novo_duty = '0;
        model_reset();

        #2;
        chk("rst_pwm",    pwm,        0);
        chk("rst_duty",   duty_atual, 0);
        chk("rst_pronto", hs.pronto,  0);
        chk("rst_rampa",  em_rampa,   0);
        @(posedge clock);
        #1;
        zera_as_n = 1'b1;

        habilita = 1'b1;
        tick();
        chk("pronto_after_en", hs.pronto, 1);
        hi = 0;
        repeat (3 * M) begin tick(); hi += int'(pwm); end
        chk("idle_pwm_low", hi, 0);

        load(10);
        wait_idle(200);
        hi = 0;
        repeat (M) begin tick(); hi += int'(pwm); end
        chk("high_count_10", hi, 10);

        load(31);
        wait_idle(400);
        chk("clamp_20", duty_atual, 20);
        hi = 0;
        repeat (M) begin tick(); hi += int'(pwm); end
        chk("high_count_20", hi, 20);

        load(0);
        wait_idle(400);
        chk("down_to_0", duty_atual, 0);

        // Transfer on the boundary cycle while steady: no step on that edge.
        load(8);
        wait_idle(400);
        while (Q != N'(M - 1)) tick();
        hs.novo_duty = 5'd12;
        hs.carrega   = 1'b1;
        tick();
        hs.carrega   = 1'b0;
        chk("coinc_nostep", duty_atual, 8);
        chk("coinc_ramp",   em_rampa,   1);
        while (Q != N'(M - 1)) tick();
        tick();
        chk("coinc_next", duty_atual, 12);
        wait_idle(100);

        // Counter frozen mid-ramp.
        load(0);
        wait_idle(400);
        load(20);
        repeat (M + 3) tick();
        conta = 1'b0;
        saved = m_duty;
        repeat (50) tick();
        chk("frozen", duty_atual, saved);
        conta = 1'b1;
        wait_idle(400);
        chk("resume_20", duty_atual, 20);

        // Enable dropped mid-ramp.
        load(0);
        wait_idle(400);
        load(20);
        repeat (M + 3) tick();
        habilita = 1'b0;
        tick();
        chk("dis_pwm",    pwm,        0);
        chk("dis_duty",   duty_atual, 0);
        chk("dis_pronto", hs.pronto,  0);

        // Asynchronous reset between edges while ramping.
        habilita = 1'b1;
        tick();
        load(16);
        repeat (25) tick();
        #3;
        zera_as_n = 1'b0;
        #1;
        chk("arst_pwm",    pwm,        0);
        chk("arst_duty",   duty_atual, 0);
        chk("arst_pronto", hs.pronto,  0);
        chk("arst_rampa",  em_rampa,   0);
        model_reset();
        @(posedge clock);
        #1;
        zera_as_n = 1'b1;

        // Randomized traffic.
        repeat (3000) begin
            conta        = ($urandom_range(0, 9) != 0);
            habilita     = ($urandom_range(0, 199) != 0);
            hs.carrega   = ($urandom_range(0, 7) == 0);
            hs.novo_duty = N'($urandom_range(0, 31));
            tick();
        end
        hs.carrega = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
